// File: rtl/qspi_fetch_ctrl.sv
// Quad-SPI read sequencer: turns byte requests into command/address/dummy/data flash
// transactions, keeping chip-select low between requests so sequential bytes cost 2 flash clocks.
module qspi_fetch_ctrl #(
   parameter int unsigned          ADDR_BITS     = 24,
   parameter int unsigned          REQ_ADDR_BITS = 13,
   parameter logic [ADDR_BITS-1:0] FLASH_BASE    = '0,
   parameter logic [7:0]           CMD_BYTE      = 8'hEB,
   parameter int unsigned          DUMMY_CYCLES  = 6,
   parameter int unsigned          CS_HIGH_MIN   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   input  logic [REQ_ADDR_BITS-1:0] req_addr,
   output logic                     req_ready,
   output logic                     rsp_valid,
   output logic [7:0]               rsp_data,
   output logic                     busy,
   output logic                     qspi_sclk,
   output logic                     qspi_select,
   output logic [3:0]               qspi_io_out,
   output logic [3:0]               qspi_io_oe,
   input  logic [3:0]               qspi_io_in
);

   localparam logic [7:0] E_ADDR  = 8'd8;
   localparam logic [7:0] E_DUMMY = 8'(8 + ADDR_BITS / 4);
   localparam logic [7:0] E_DATA  = 8'(8 + ADDR_BITS / 4 + DUMMY_CYCLES);
   localparam logic [7:0] E_END   = 8'(8 + ADDR_BITS / 4 + DUMMY_CYCLES + 2);

   typedef enum logic [2:0] {
      DESEL,
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      DATA,
      HOLD
   } state_t;

   state_t                 state_q, state_d;
   logic [7:0]             hold_cnt_q, hold_cnt_d;
   logic [7:0]             edge_q, edge_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [ADDR_BITS-1:0]   sh_q, sh_d;
   logic [7:0]             data_sr_q, data_sr_d;
   logic                   sclk_q, sclk_d;
   logic                   sel_q, sel_d;
   logic [3:0]             io_out_q, io_out_d;
   logic [3:0]             io_oe_q, io_oe_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [7:0]             rsp_data_q, rsp_data_d;
   logic                   pend_q, pend_d;

   logic [ADDR_BITS-1:0]   req_flash;
   logic [ADDR_BITS-1:0]   start_addr;
   logic                   start;
   logic                   accept;
   logic [7:0]             nxt_edge;

   assign req_flash   = FLASH_BASE + ADDR_BITS'(req_addr);
   assign req_ready   = (state_q == IDLE) || (state_q == HOLD);
   assign accept      = req_valid && req_ready;
   assign busy        = pend_q || (state_q == CMD) || (state_q == ADDR) ||
                        (state_q == DUMMY) || (state_q == DATA);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign qspi_sclk   = sclk_q;
   assign qspi_select = sel_q;
   assign qspi_io_out = io_out_q;
   assign qspi_io_oe  = io_oe_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DESEL;
         hold_cnt_q  <= 8'(CS_HIGH_MIN);
         edge_q      <= '0;
         addr_q      <= '0;
         sh_q        <= '0;
         data_sr_q   <= '0;
         sclk_q      <= 1'b0;
         sel_q       <= 1'b1;
         io_out_q    <= '0;
         io_oe_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         pend_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         edge_q      <= edge_d;
         addr_q      <= addr_d;
         sh_q        <= sh_d;
         data_sr_q   <= data_sr_d;
         sclk_q      <= sclk_d;
         sel_q       <= sel_d;
         io_out_q    <= io_out_d;
         io_oe_q     <= io_oe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         pend_q      <= pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      edge_d      = edge_q;
      addr_d      = addr_q;
      sh_d        = sh_q;
      data_sr_d   = data_sr_q;
      sclk_d      = sclk_q;
      sel_d       = sel_q;
      io_out_d    = io_out_q;
      io_oe_d     = io_oe_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      pend_d      = pend_q;
      start       = 1'b0;
      start_addr  = req_flash;
      nxt_edge    = edge_q + 8'd1;

      case (state_q)
         DESEL: begin
            if (hold_cnt_q <= 8'd1) begin
               if (pend_q) begin
                  start      = 1'b1;
                  start_addr = addr_q;
                  pend_d     = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end
         end
         IDLE: begin
            if (accept) start = 1'b1;
         end
         HOLD: begin
            if (accept) begin
               addr_d = req_flash;
               if (req_flash == addr_q + 1'b1) begin
                  state_d = DATA;
                  edge_d  = E_DATA;
               end else begin
                  // Non-sequential: keep the address and replay the full transaction after deselect
                  state_d    = DESEL;
                  sel_d      = 1'b1;
                  hold_cnt_d = 8'(CS_HIGH_MIN);
                  pend_d     = 1'b1;
               end
            end
         end
         CMD, ADDR, DUMMY, DATA: begin
            if (!sclk_q) begin
               sclk_d = 1'b1;
               if (state_q == DATA) data_sr_d = {data_sr_q[3:0], qspi_io_in};
            end else begin
               // Falling edge: advance to the next rising-edge index and set up its outputs
               sclk_d = 1'b0;
               edge_d = nxt_edge;
               if (nxt_edge < E_ADDR) begin
                  io_out_d = {3'b000, CMD_BYTE[~nxt_edge[2:0]]};
               end else if (nxt_edge < E_DUMMY) begin
                  state_d  = ADDR;
                  io_oe_d  = '1;
                  io_out_d = sh_q[ADDR_BITS-1 -: 4];
                  sh_d     = sh_q << 4;
               end else if (nxt_edge < E_DATA) begin
                  state_d  = DUMMY;
                  io_oe_d  = '0;
                  io_out_d = '0;
               end else if (nxt_edge < E_END) begin
                  state_d  = DATA;
                  io_oe_d  = '0;
                  io_out_d = '0;
               end else begin
                  state_d     = HOLD;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = data_sr_q;
               end
            end
         end
         default: state_d = DESEL;
      endcase

      if (start) begin
         state_d  = CMD;
         sel_d    = 1'b0;
         sclk_d   = 1'b0;
         edge_d   = '0;
         addr_d   = start_addr;
         sh_d     = start_addr;
         io_out_d = {3'b000, CMD_BYTE[7]};
         io_oe_d  = 4'b0001;
      end
   end

endmodule
